// File: rtl/tama_pkg.sv
// ============================================================================
// Module : tama_pkg
// Brief  : Shared constants and FSM encoding for the pet-stat scheduler.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package tama_pkg;

    localparam int STAT_MAX  = 15;
    localparam int NUM_STATS = 6;

    // Stat slots inside the packed 24-bit stats vector (nibble index)
    localparam int HUNGER    = 0;
    localparam int HAPPINESS = 1;
    localparam int HEALTH    = 2;
    localparam int HYGIENE   = 3;
    localparam int ENERGY    = 4;
    localparam int SOCIAL    = 5;

    localparam logic [2:0] CMD_FEED  = 3'd0;
    localparam logic [2:0] CMD_PLAY  = 3'd1;
    localparam logic [2:0] CMD_CLEAN = 3'd2;
    localparam logic [2:0] CMD_SLEEP = 3'd3;
    localparam logic [2:0] CMD_HEAL  = 3'd4;
    localparam logic [2:0] CMD_TALK  = 3'd5;

    localparam int REQ_CMD   = 0;
    localparam int REQ_DECAY = 1;
    localparam int REQ_EVENT = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_APPLY = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/tama_rr_arb.sv
// ============================================================================
// Module : tama_rr_arb
// Brief  : 3-way round-robin arbiter; pointer moves one past the winner.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tama_rr_arb
    import tama_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] i_req,
    input  logic       i_advance,
    output logic [2:0] o_gnt
);

    logic [1:0] r_ptr;
    logic [1:0] w_ptr_nxt;

    always_comb begin
        o_gnt = 3'b000;
        unique case (r_ptr)
            2'd1: begin
                if (i_req[1])      o_gnt = 3'b010;
                else if (i_req[2]) o_gnt = 3'b100;
                else if (i_req[0]) o_gnt = 3'b001;
            end
            2'd2: begin
                if (i_req[2])      o_gnt = 3'b100;
                else if (i_req[0]) o_gnt = 3'b001;
                else if (i_req[1]) o_gnt = 3'b010;
            end
            default: begin
                if (i_req[0])      o_gnt = 3'b001;
                else if (i_req[1]) o_gnt = 3'b010;
                else if (i_req[2]) o_gnt = 3'b100;
            end
        endcase
    end

    always_comb begin
        w_ptr_nxt = r_ptr;
        if (o_gnt[0])      w_ptr_nxt = 2'd1;
        else if (o_gnt[1]) w_ptr_nxt = 2'd2;
        else if (o_gnt[2]) w_ptr_nxt = 2'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 2'(REQ_CMD);
        end else if (i_advance) begin
            r_ptr <= w_ptr_nxt;
        end
    end

endmodule

`default_nettype wire

// File: rtl/tama_stat_scheduler.sv
// ============================================================================
// Module : tama_stat_scheduler
// Brief  : Owns six 4-bit pet stats; serialises command/decay/event updates
//          through one saturating read-modify-write path.
//          Optional macro TAMA_DROP_CNT_EN enables the lost-request counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tama_stat_scheduler
    import tama_pkg::*;
#(
    parameter int DECAY_PERIOD = 10,
    parameter int CMD_DELTA    = 3,
    parameter int STAT_INIT    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_i,
    input  logic [7:0]  rnd_i,
    input  logic        cmd_valid_i,
    input  logic [2:0]  cmd_code_i,
    output logic        cmd_ready_o,
    output logic [23:0] stats_o,
    output logic [2:0]  grant_o,
    output logic        upd_done_o,
    output logic        cmd_err_o,
    output logic [7:0]  drop_cnt_o
);

    localparam int             c_CNT_W = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
    localparam logic [c_CNT_W-1:0] c_WRAP = c_CNT_W'(DECAY_PERIOD - 1);
    localparam logic [3:0]     c_DELTA = 4'(CMD_DELTA);
    localparam logic [3:0]     c_INIT  = 4'(STAT_INIT);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_cmd_pend;
    logic                r_decay_pend;
    logic                r_event_pend;
    logic [2:0]          r_cmd_code;
    logic [2:0]          r_evt_tgt;
    logic [2:0]          r_apply_tgt;
    logic [2:0]          r_grant;
    logic [c_CNT_W-1:0]  r_decay_cnt;
    logic [23:0]         r_stats;
    logic [23:0]         w_stats_nxt;
    logic [2:0]          w_gnt;
    logic [2:0]          w_clr;
    logic                w_in_arb;
    logic                w_cmd_req;
    logic                w_decay_req;
    logic                w_event_req;
    logic                w_keep_cmd;
    logic                w_keep_decay;
    logic                w_keep_event;
    logic                w_unused_rnd;

    function automatic logic [3:0] sat_add(input logic [3:0] a, input logic [3:0] d);
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, d};
        return (s > 5'(STAT_MAX)) ? 4'(STAT_MAX) : s[3:0];
    endfunction

    function automatic logic [3:0] sat_sub(input logic [3:0] a, input logic [3:0] d);
        return (a < d) ? 4'd0 : (a - d);
    endfunction

    assign w_unused_rnd = rnd_i[3];

    assign cmd_ready_o = (r_state == ST_IDLE) & ~r_cmd_pend;
    assign stats_o     = r_stats;

    assign w_in_arb    = (r_state == ST_ARB);
    assign w_clr       = w_in_arb ? w_gnt : 3'b000;
    assign w_cmd_req   = cmd_valid_i & cmd_ready_o;
    assign w_decay_req = tick_i & (r_decay_cnt == c_WRAP);
    assign w_event_req = tick_i & (rnd_i[7:4] == 4'd0);

    // A pend that survives this edge without being granted blocks a new request
    assign w_keep_cmd   = r_cmd_pend   & ~w_clr[REQ_CMD];
    assign w_keep_decay = r_decay_pend & ~w_clr[REQ_DECAY];
    assign w_keep_event = r_event_pend & ~w_clr[REQ_EVENT];

    tama_rr_arb u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     ({r_event_pend, r_decay_pend, r_cmd_pend}),
        .i_advance (w_in_arb),
        .o_gnt     (w_gnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        grant_o     = 3'b000;
        upd_done_o  = 1'b0;
        cmd_err_o   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (r_cmd_pend | r_decay_pend | r_event_pend) w_state_nxt = ST_ARB;
            end
            ST_ARB: begin
                w_state_nxt = ST_APPLY;
            end
            ST_APPLY: begin
                w_state_nxt = ST_DONE;
                grant_o     = r_grant;
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                upd_done_o  = 1'b1;
                cmd_err_o   = r_grant[REQ_CMD] & (r_cmd_code > CMD_TALK);
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_pend   <= 1'b0;
            r_decay_pend <= 1'b0;
            r_event_pend <= 1'b0;
            r_cmd_code   <= 3'd0;
            r_evt_tgt    <= 3'd0;
            r_apply_tgt  <= 3'd0;
            r_grant      <= 3'b000;
            r_decay_cnt  <= '0;
            r_stats      <= {NUM_STATS{c_INIT}};
        end else begin
            r_cmd_pend   <= w_cmd_req   | w_keep_cmd;
            r_decay_pend <= w_decay_req | w_keep_decay;
            r_event_pend <= w_event_req | w_keep_event;
            if (w_cmd_req) begin
                r_cmd_code <= cmd_code_i;
            end
            if (w_event_req && !w_keep_event) begin
                r_evt_tgt <= rnd_i[2:0];
            end
            if (tick_i) begin
                r_decay_cnt <= (r_decay_cnt == c_WRAP) ? '0 : r_decay_cnt + c_CNT_W'(1);
            end
            // Snapshot the target so an event arriving during ARB cannot retarget this update
            if (w_in_arb) begin
                r_grant     <= w_gnt;
                r_apply_tgt <= r_evt_tgt;
            end
            if (r_state == ST_APPLY) begin
                r_stats <= w_stats_nxt;
            end
        end
    end

    always_comb begin
        w_stats_nxt = r_stats;
        if (r_grant[REQ_CMD]) begin
            unique case (r_cmd_code)
                CMD_FEED: begin
                    w_stats_nxt[HUNGER*4 +: 4]  = sat_add(r_stats[HUNGER*4 +: 4], c_DELTA);
                    w_stats_nxt[HYGIENE*4 +: 4] = sat_sub(r_stats[HYGIENE*4 +: 4], 4'd1);
                end
                CMD_PLAY: begin
                    w_stats_nxt[HAPPINESS*4 +: 4] = sat_add(r_stats[HAPPINESS*4 +: 4], c_DELTA);
                    w_stats_nxt[ENERGY*4 +: 4]    = sat_sub(r_stats[ENERGY*4 +: 4], 4'd1);
                end
                CMD_CLEAN: w_stats_nxt[HYGIENE*4 +: 4] = sat_add(r_stats[HYGIENE*4 +: 4], c_DELTA);
                CMD_SLEEP: w_stats_nxt[ENERGY*4 +: 4]  = sat_add(r_stats[ENERGY*4 +: 4], c_DELTA);
                CMD_HEAL:  w_stats_nxt[HEALTH*4 +: 4]  = sat_add(r_stats[HEALTH*4 +: 4], c_DELTA);
                CMD_TALK: begin
                    w_stats_nxt[SOCIAL*4 +: 4]    = sat_add(r_stats[SOCIAL*4 +: 4], c_DELTA);
                    w_stats_nxt[HAPPINESS*4 +: 4] = sat_add(r_stats[HAPPINESS*4 +: 4], 4'd1);
                end
                default: w_stats_nxt = r_stats;
            endcase
        end else if (r_grant[REQ_DECAY]) begin
            for (int i = 0; i < NUM_STATS; i++) begin
                w_stats_nxt[i*4 +: 4] = sat_sub(r_stats[i*4 +: 4], 4'd1);
            end
            if (r_stats[HUNGER*4 +: 4] == 4'd0) begin
                w_stats_nxt[HEALTH*4 +: 4] = sat_sub(r_stats[HEALTH*4 +: 4], 4'd2);
            end
        end else if (r_grant[REQ_EVENT]) begin
            for (int i = 0; i < NUM_STATS; i++) begin
                if (r_apply_tgt == 3'(i)) begin
                    w_stats_nxt[i*4 +: 4] = sat_sub(r_stats[i*4 +: 4], 4'd2);
                end
            end
        end
    end

`ifdef TAMA_DROP_CNT_EN
    logic [7:0] r_drop_cnt;
    logic [1:0] w_drop_inc;
    logic [8:0] w_drop_sum;

    assign w_drop_inc = {1'b0, w_decay_req & w_keep_decay} + {1'b0, w_event_req & w_keep_event};
    assign w_drop_sum = {1'b0, r_drop_cnt} + {7'd0, w_drop_inc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= 8'd0;
        end else begin
            r_drop_cnt <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
        end
    end

    assign drop_cnt_o = r_drop_cnt;
`else
    assign drop_cnt_o = 8'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tama_stat_scheduler.sv
// ============================================================================
// Module : tb_tama_stat_scheduler
// Brief  : Scoreboard bench for tama_stat_scheduler with a behavioural model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tama_stat_scheduler;

    localparam int DP = 10;
    localparam int CD = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        tick_i = 1'b0;
    logic [7:0]  rnd_i = 8'd0;
    logic        cmd_valid_i = 1'b0;
    logic [2:0]  cmd_code_i = 3'd0;
    logic        cmd_ready_o;
    logic [23:0] stats_o;
    logic [2:0]  grant_o;
    logic        upd_done_o;
    logic        cmd_err_o;
    logic [7:0]  drop_cnt_o;

    tama_stat_scheduler #(.DECAY_PERIOD(DP), .CMD_DELTA(CD), .STAT_INIT(8)) dut (
        .clk(clk), .rst_n(rst_n), .tick_i(tick_i), .rnd_i(rnd_i),
        .cmd_valid_i(cmd_valid_i), .cmd_code_i(cmd_code_i), .cmd_ready_o(cmd_ready_o),
        .stats_o(stats_o), .grant_o(grant_o), .upd_done_o(upd_done_o),
        .cmd_err_o(cmd_err_o), .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] stats;
        logic        err;
        logic [2:0]  grant;
    } exp_t;

    exp_t        sbq[$];
    logic [2:0]  gseq[$];
    int          n_pass = 0;
    int          n_total = 0;

    // Model: phase 0 idle, 1 arbitrate, 2 apply, 3 done; requester 0 cmd, 1 decay, 2 event
    int          m_stat[6];
    int          m_phase, m_ptr, m_dcnt, m_code, m_tgt, m_drop;
    bit          m_pend[3];
    logic [2:0]  m_grant;
    logic [2:0]  last_grant;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_total++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    endtask

    function automatic int clamp(input int x);
        return (x < 0) ? 0 : ((x > 15) ? 15 : x);
    endfunction

    function automatic int prim(input int code);
        case (code)
            0: return 0;
            1: return 1;
            2: return 3;
            3: return 4;
            4: return 2;
            default: return 5;
        endcase
    endfunction

    function automatic logic [23:0] pack_stats();
        logic [23:0] v;
        for (int i = 0; i < 6; i++) v[i*4 +: 4] = 4'(m_stat[i]);
        return v;
    endfunction

    function automatic logic [7:0] exp_drop();
`ifdef TAMA_DROP_CNT_EN
        return 8'(m_drop);
`else
        return 8'd0;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 6; i++) m_stat[i] = 8;
        for (int i = 0; i < 3; i++) m_pend[i] = 1'b0;
        m_phase = 0; m_ptr = 0; m_dcnt = 0; m_code = 0; m_tgt = 0; m_drop = 0;
        m_grant = 3'b000; last_grant = 3'b000;
        sbq.delete();
        gseq.delete();
    endtask

    task automatic model_apply(input int r);
        int   old[6];
        exp_t e;
        old   = m_stat;
        e.err = 1'b0;
        case (r)
            0: begin
                if (m_code >= 6) e.err = 1'b1;
                else begin
                    m_stat[prim(m_code)] = clamp(old[prim(m_code)] + CD);
                    if (m_code == 0) m_stat[3] = clamp(old[3] - 1);
                    if (m_code == 1) m_stat[4] = clamp(old[4] - 1);
                    if (m_code == 5) m_stat[1] = clamp(old[1] + 1);
                end
            end
            1: for (int i = 0; i < 6; i++) m_stat[i] = clamp(old[i] - 1 - ((i == 2 && old[0] == 0) ? 1 : 0));
            default: if (m_tgt < 6) m_stat[m_tgt] = clamp(old[m_tgt] - 2);
        endcase
        m_grant = 3'(1 << r);
        e.stats = pack_stats();
        e.grant = m_grant;
        sbq.push_back(e);
    endtask

    task automatic model_step();
        bit req[3];
        bit clr[3];
        int nphase;
        int r;
        nphase = (m_phase == 0) ? ((m_pend[0] | m_pend[1] | m_pend[2]) ? 1 : 0) : (m_phase + 1) % 4;
        for (int i = 0; i < 3; i++) clr[i] = 1'b0;
        req[0] = cmd_valid_i && (m_phase == 0) && !m_pend[0];
        req[1] = 1'b0;
        req[2] = tick_i && (rnd_i[7:4] == 4'd0);
        if (tick_i) begin
            if (m_dcnt == DP - 1) begin req[1] = 1'b1; m_dcnt = 0; end
            else m_dcnt++;
        end
        if (m_phase == 1) begin
            for (int k = 0; k < 3; k++) begin
                r = (m_ptr + k) % 3;
                if (m_pend[r]) begin
                    clr[r] = 1'b1;
                    model_apply(r);
                    m_ptr = (r + 1) % 3;
                    break;
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (req[i] && m_pend[i] && !clr[i]) begin
                if (m_drop < 255) m_drop++;
            end else if (req[i]) begin
                m_pend[i] = 1'b1;
                if (i == 0) m_code = int'(cmd_code_i);
                if (i == 2) m_tgt = int'(rnd_i[2:0]);
            end else if (clr[i]) begin
                m_pend[i] = 1'b0;
            end
        end
        m_phase = nphase;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            check("cmd_ready", 32'(cmd_ready_o), 32'((m_phase == 0) && !m_pend[0]));
            check("upd_done", 32'(upd_done_o), 32'(m_phase == 3));
            check("grant", 32'(grant_o), 32'((m_phase == 2) ? m_grant : 3'b000));
            check("drop_cnt", 32'(drop_cnt_o), 32'(exp_drop()));
            if (grant_o != 3'b000) begin
                last_grant = grant_o;
                gseq.push_back(grant_o);
            end
            if (upd_done_o) begin
                if (sbq.size() == 0) begin
                    n_total++;
                    $display("FAIL sb_underflow: upd_done with stats %0h, no expected update", stats_o);
                end else begin
                    e = sbq.pop_front();
                    check("sb_stats", 32'(stats_o), 32'(e.stats));
                    check("sb_cmd_err", 32'(cmd_err_o), 32'(e.err));
                    check("sb_grant", 32'(last_grant), 32'(e.grant));
                end
            end else begin
                check("cmd_err_quiet", 32'(cmd_err_o), 32'd0);
            end
        end
    end

    task automatic do_reset();
        cmd_valid_i = 1'b0; tick_i = 1'b0; rnd_i = 8'd0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_cmd(input logic [2:0] code);
        int t;
        t = 0;
        while (!cmd_ready_o && t < 100) begin @(negedge clk); t++; end
        if (!cmd_ready_o) begin
            n_total++;
            $display("FAIL cmd_ready_timeout: ready=%0b required 1", cmd_ready_o);
        end
        cmd_valid_i = 1'b1; cmd_code_i = code;
        @(negedge clk);
        cmd_valid_i = 1'b0;
    endtask

    task automatic do_tick(input logic [7:0] rnd);
        tick_i = 1'b1; rnd_i = rnd;
        @(negedge clk);
        tick_i = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        #1 rst_n = 1'b0;
        #1;
        check("rst_stats", 32'(stats_o), 32'h888888);
        check("rst_ready", 32'(cmd_ready_o), 32'd1);
        check("rst_drop", 32'(drop_cnt_o), 32'd0);
        check("rst_grant", 32'(grant_o), 32'd0);
        check("rst_done", 32'(upd_done_o), 32'd0);
        check("rst_err", 32'(cmd_err_o), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Feed from reset: result visible on the third edge after acceptance
        do_cmd(3'd0);
        @(negedge clk);
        @(negedge clk);
        check("feed_lat_early", 32'(upd_done_o), 32'd0);
        @(negedge clk);
        check("feed_lat_done", 32'(upd_done_o), 32'd1);
        check("feed_stats", 32'(stats_o), 32'h88788B);
        repeat (3) @(negedge clk);

        // Asynchronous reset while an update is being applied
        do_cmd(3'd1);
        t = 0;
        while (grant_o == 3'b000 && t < 20) begin @(negedge clk); t++; end
        check("apply_seen", 32'(grant_o != 3'b000), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("apply_rst_stats", 32'(stats_o), 32'h888888);
        check("apply_rst_ready", 32'(cmd_ready_o), 32'd1);
        check("apply_rst_grant", 32'(grant_o), 32'd0);
        check("apply_rst_drop", 32'(drop_cnt_o), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Ten ticks without events -> one decay
        for (int i = 0; i < 10; i++) begin do_tick(8'hF0); @(negedge clk); end
        repeat (8) @(negedge clk);
        check("decay_stats", 32'(stats_o), 32'h777777);

        // Drain hunger with events, then decay hits health twice
        do_reset();
        for (int i = 0; i < 4; i++) begin do_tick(8'h00); repeat (6) @(negedge clk); end
        for (int i = 0; i < 6; i++) begin do_tick(8'hF0); @(negedge clk); end
        repeat (8) @(negedge clk);
        check("decay_starved", 32'(stats_o), 32'h777670);

        // Command, decay wrap and event all raised on one edge
        do_reset();
        for (int i = 0; i < 9; i++) begin do_tick(8'hF0); @(negedge clk); end
        repeat (4) @(negedge clk);
        gseq.delete();
        cmd_valid_i = 1'b1; cmd_code_i = 3'd4; tick_i = 1'b1; rnd_i = 8'h03;
        @(negedge clk);
        cmd_valid_i = 1'b0; tick_i = 1'b0;
        repeat (20) @(negedge clk);
        check("order_count", 32'(gseq.size()), 32'd3);
        if (gseq.size() == 3) begin
            check("order_0", 32'(gseq[0]), 32'd1);
            check("order_1", 32'(gseq[1]), 32'd2);
            check("order_2", 32'(gseq[2]), 32'd4);
        end
        check("order_stats", 32'(stats_o), 32'h775A77);

        // Saturation at 15 and an illegal command
        do_reset();
        for (int i = 0; i < 6; i++) do_cmd(3'd4);
        repeat (6) @(negedge clk);
        check("heal_sat", 32'(stats_o), 32'h888F88);
        do_cmd(3'd7);
        repeat (6) @(negedge clk);
        check("illegal_nochange", 32'(stats_o), 32'h888F88);

        // Event requests stalled behind a command
        do_reset();
        cmd_valid_i = 1'b1; cmd_code_i = 3'd2;
        @(negedge clk);
        cmd_valid_i = 1'b0; tick_i = 1'b1; rnd_i = 8'h00;
        repeat (3) @(negedge clk);
        tick_i = 1'b0;
        repeat (12) @(negedge clk);
`ifdef TAMA_DROP_CNT_EN
        check("drop_final", 32'(drop_cnt_o), 32'd2);
`else
        check("drop_final", 32'(drop_cnt_o), 32'd0);
`endif

        // Randomised traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            tick_i      = ($urandom_range(0, 3) == 0);
            rnd_i       = ($urandom_range(0, 2) == 0) ? {4'h0, 4'($urandom)} : 8'($urandom);
            cmd_valid_i = $urandom_range(0, 1) == 1;
            cmd_code_i  = 3'($urandom_range(0, 7));
            @(negedge clk);
        end
        cmd_valid_i = 1'b0; tick_i = 1'b0;
        repeat (40) @(negedge clk);
        check("sb_drained", 32'(sbq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
